// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants (opcodes also decoded by main_decoder), beat class codes
// and per-format bit-packing helpers for the instruction encoder.
package instr_encoder_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [2:0] Funct3Word = 3'b010;
    localparam logic [2:0] Funct3Jalr = 3'b000;
    localparam logic [2:0] Funct3Sll  = 3'b001;
    localparam logic [2:0] Funct3Srx  = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NopWord = 32'h00000013;

    typedef enum logic [3:0] {
        ClsLw     = 4'd0,
        ClsSw     = 4'd1,
        ClsR      = 4'd2,
        ClsBranch = 4'd3,
        ClsIalu   = 4'd4,
        ClsJal    = 4'd5,
        ClsLui    = 4'd6,
        ClsAuipc  = 4'd7,
        ClsJalr   = 4'd8
    } instr_cls_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } enc_state_e;

    function automatic logic cls_legal(logic [3:0] cls);
        return cls <= 4'd8;
    endfunction

    function automatic logic [31:0] pack_r(logic [6:0] funct7, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] funct3, logic [4:0] rd,
                                           logic [6:0] opcode);
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] pack_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] funct3,
                                           logic [4:0] rd, logic [6:0] opcode);
        return {imm, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] pack_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] funct3, logic [6:0] opcode);
        return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
    endfunction

    function automatic logic [31:0] pack_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [2:0] funct3, logic [6:0] opcode);
        return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    endfunction

    function automatic logic [31:0] pack_u(logic [31:12] imm, logic [4:0] rd, logic [6:0] opcode);
        return {imm, rd, opcode};
    endfunction

    function automatic logic [31:0] pack_j(logic [20:1] imm, logic [4:0] rd, logic [6:0] opcode);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: symbolic instruction class plus fields to a 32-bit RV32I word.
// Immediate bits outside the chosen format are dropped; illegal classes yield a nop.
module instr_encoder_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    logic [6:0]  funct7;
    logic [11:0] ialu_imm;

    assign funct7 = {1'b0, f7b5, 5'b00000};

    // Shift-immediates carry funct7 in imm[11:5] and the shift amount in imm[4:0].
    always_comb begin
        ialu_imm = imm[11:0];
        if (funct3 == Funct3Sll || funct3 == Funct3Srx) begin
            ialu_imm = {funct7, imm[4:0]};
        end
    end

    always_comb begin
        word = NopWord;
        case (instr_cls_e'(cls))
            ClsLw:     word = pack_i(imm[11:0], rs1, Funct3Word, rd, OpLoad);
            ClsSw:     word = pack_s(imm[11:0], rs2, rs1, Funct3Word, OpStore);
            ClsR:      word = pack_r(funct7, rs2, rs1, funct3, rd, OpOp);
            ClsBranch: word = pack_b(imm[12:1], rs2, rs1, funct3, OpBranch);
            ClsIalu:   word = pack_i(ialu_imm, rs1, funct3, rd, OpOpImm);
            ClsJal:    word = pack_j(imm[20:1], rd, OpJal);
            ClsLui:    word = pack_u(imm[31:12], rd, OpLui);
            ClsAuipc:  word = pack_u(imm[31:12], rd, OpAuipc);
            ClsJalr:   word = pack_i(imm[11:0], rs1, Funct3Jalr, rd, OpJalr);
            default:   word = NopWord;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic RV32I beats into instruction memory: each accepted beat is encoded and
// written one cycle later at the next sequential word address of the current load session.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_cls,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TopAddr  = '1;

    enc_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W:0]   count_q;

    logic [31:0] packed_word;
    logic        accept;
    logic        at_top;

    instr_encoder_field_pack u_field_pack (
        .cls    (in_cls),
        .funct3 (in_funct3),
        .f7b5   (in_f7b5),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .word   (packed_word)
    );

    assign in_ready = (state_q == StRun) && !start;
    assign accept   = in_valid && in_ready;
    assign at_top   = (ptr_q == TopAddr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= BaseAddr;
            addr_q  <= BaseAddr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q  <= ptr_q;
                wdata_q <= packed_word;
                count_q <= count_q + (ADDR_W + 1)'(1);
                // The pointer saturates at the top word; the session ends there instead.
                if (!at_top) begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
                if (!cls_legal(in_cls)) begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: ;
                StRun: begin
                    if (accept && (in_last || at_top)) begin
                        state_q <= StDone;
                        if (!in_last) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StDone: ;
                default: state_q <= StIdle;
            endcase

            // A restart leaves any already-registered write untouched so it still completes.
            if (start) begin
                state_q <= StRun;
                ptr_q   <= BaseAddr;
                count_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign count     = count_q;
    assign done      = (state_q == StDone);
    assign busy      = (state_q == StRun) || we_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (256-word and 4-word memories) share one beat stream
// and are checked every cycle against a session-level model plus hand-computed words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  in_cls;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;

    logic        rdy8, we8, busy8, done8, err8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic [8:0]  cnt8;
    logic        rdy2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy8),
        .in_last(in_last), .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8), .busy(busy8), .done(done8),
        .err(err8), .count(cnt8)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_last(in_last), .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2), .done(done2),
        .err(err2), .count(cnt2)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Instruction word straight from the RV32I field layout, using integer shifts and masks.
    function automatic logic [31:0] model_enc(logic [3:0] cls, logic [2:0] f3, logic f7,
                                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                              logic [31:0] imm);
        int unsigned i   = imm;
        int unsigned d   = int'(rd) << 7;
        int unsigned s1  = int'(rs1) << 15;
        int unsigned s2  = int'(rs2) << 20;
        int unsigned fn3 = int'(f3) << 12;
        int unsigned fn7 = (f7 ? 32 : 0);
        int unsigned sh;
        case (cls)
            4'd0: return ((i & 'hFFF) << 20) | s1 | (2 << 12) | d | 'h03;
            4'd1: return (((i >> 5) & 'h7F) << 25) | s2 | s1 | (2 << 12) | ((i & 'h1F) << 7) | 'h23;
            4'd2: return (fn7 << 25) | s2 | s1 | fn3 | d | 'h33;
            4'd3: return (((i >> 12) & 1) << 31) | (((i >> 5) & 'h3F) << 25) | s2 | s1 | fn3
                         | (((i >> 1) & 'hF) << 8) | (((i >> 11) & 1) << 7) | 'h63;
            4'd4: begin
                sh = (f3 == 3'd1 || f3 == 3'd5) ? ((fn7 << 5) | (i & 'h1F)) : (i & 'hFFF);
                return (sh << 20) | s1 | fn3 | d | 'h13;
            end
            4'd5: return (((i >> 20) & 1) << 31) | (((i >> 1) & 'h3FF) << 21)
                         | (((i >> 11) & 1) << 20) | (((i >> 12) & 'hFF) << 12) | d | 'h6F;
            4'd6: return (i & 'hFFFFF000) | d | 'h37;
            4'd7: return (i & 'hFFFFF000) | d | 'h17;
            4'd8: return ((i & 'hFFF) << 20) | s1 | d | 'h67;
            default: return 32'h13;
        endcase
    endfunction

    // Session model per instance: 0 idle, 1 loading, 2 finished. Address = base + words written.
    int          depth [2] = '{256, 4};
    int          m_st  [2];
    int          m_cnt [2];
    bit          m_err [2];
    bit          m_we  [2];
    int          m_addr[2];
    logic [31:0] m_wd  [2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_st[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
            end else begin
                m_we[k] = (m_st[k] == 1) && !start && in_valid;
                if (m_we[k]) begin
                    m_addr[k] = m_cnt[k];
                    m_wd[k]   = model_enc(in_cls, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm);
                    m_cnt[k]++;
                    if (in_cls > 4'd8) m_err[k] = 1;
                    if (in_last) m_st[k] = 2;
                    else if (m_cnt[k] == depth[k]) begin
                        m_st[k] = 2;
                        m_err[k] = 1;
                    end
                end
                if (start) begin
                    m_st[k] = 1; m_cnt[k] = 0; m_err[k] = 0;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic rdy, input logic we, input logic bsy,
                       input logic dn, input logic er, input int cnt, input int addr,
                       input logic [31:0] wd);
        string p = (k == 0) ? "w8" : "w2";
        chk({p, "_in_ready"}, rdy, (m_st[k] == 1) && !start);
        chk({p, "_mem_we"}, we, m_we[k]);
        chk({p, "_busy"}, bsy, (m_st[k] == 1) || m_we[k]);
        chk({p, "_done"}, dn, m_st[k] == 2);
        chk({p, "_err"}, er, m_err[k]);
        chk({p, "_count"}, cnt, m_cnt[k]);
        if (m_we[k]) begin
            chk({p, "_mem_addr"}, addr, m_addr[k]);
            chk({p, "_mem_wdata"}, wd, m_wd[k]);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, rdy8, we8, busy8, done8, err8, int'(cnt8), int'(addr8), wd8);
        cmp(1, rdy2, we2, busy2, done2, err2, int'(cnt2), int'(addr2), wd2);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one beat for one cycle; returns #1 after the accepting edge (write cycle).
    task automatic beat(input logic [3:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_cls = cls; in_funct3 = f3; in_f7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_cls = '0;
        in_funct3 = '0; in_f7b5 = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", addr8, 32'h0);
        chk("reset_wdata", wd8, 32'h0);
        chk("reset_count", cnt8, 32'h0);
        chk("reset_busy", busy8, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single addi, written the cycle after acceptance.
        pulse_start();
        beat(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        chk("addi_we", we8, 32'h1);
        chk("addi_addr", addr8, 32'h0);
        chk("addi_word", wd8, 32'h00500093);
        idle();

        // Back-to-back program covering most classes.
        pulse_start();
        beat(4'd0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0);
        chk("lw_word", wd8, 32'h0080A103);
        chk("lw_addr", addr8, 32'h0);
        beat(4'd1, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0);
        chk("sw_word", wd8, 32'h0020A223);
        chk("sw_addr", addr8, 32'h1);
        chk("sw_we", we8, 32'h1);
        beat(4'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add_word", wd8, 32'h002081B3);
        beat(4'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("sub_word", wd8, 32'h402081B3);
        beat(4'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        chk("beq_word", wd8, 32'hFE208EE3);
        beat(4'd4, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'hFFFF_FFE3, 1'b0);
        chk("srai_word", wd8, 32'h40325213);
        beat(4'd7, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h0000_1ABC, 1'b0);
        chk("auipc_word", wd8, 32'h00001317);
        beat(4'd8, 3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFF8, 1'b1);
        chk("jalr_word", wd8, 32'hFF808067);
        idle();
        chk("prog_done", done8, 32'h1);
        chk("prog_count", cnt8, 32'd8);

        // jal as the only beat.
        pulse_start();
        beat(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        chk("jal_word", wd8, 32'h008000EF);
        idle();
        chk("jal_done", done8, 32'h1);
        chk("jal_count", cnt8, 32'h1);
        chk("jal_ready", rdy8, 32'h0);

        // lui, illegal class, then restart while the nop write is pending.
        pulse_start();
        beat(4'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        chk("lui_word", wd8, 32'h123452B7);
        beat(4'd12, 3'd3, 1'b1, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 1'b0);
        chk("ill_word", wd8, 32'h00000013);
        chk("ill_err", err8, 32'h1);
        in_rd = 5'd7; in_imm = 32'd1; in_cls = 4'd4; in_funct3 = 3'd0; in_f7b5 = 1'b0;
        in_rs1 = 5'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_no_accept", we8, 32'h0);
        chk("restart_count", cnt8, 32'h0);
        chk("restart_err", err8, 32'h0);
        beat(4'd4, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1);
        chk("restart_addr", addr8, 32'h0);
        chk("restart_word", wd8, 32'h00100393);
        idle();

        // Five beats without in_last: the 4-word instance fills and stops.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            beat(4'd4, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, i, 1'b0);
        end
        chk("ovf_5th_dropped", we2, 32'h0);
        chk("ovf_done", done2, 32'h1);
        chk("ovf_err", err2, 32'h1);
        chk("ovf_count", cnt2, 32'd4);
        idle();

        // Asynchronous reset in the middle of a write cycle.
        pulse_start();
        beat(4'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_we", we8, 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_we8", we8, 32'h0);
        chk("async_reset_we2", we2, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_busy", busy8, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
